// File: rtl/dpll_step_sequencer.sv
// Step sequencer for the asynchronous DPLL var chain: issues forward/backtrack
// steps over a 4-phase handshake, randomises polarity and reports SAT/UNSAT/TIMEOUT.
module dpll_step_sequencer #(
  parameter int unsigned N_VARS     = 64,
  parameter int unsigned SETTLE_CYC = 4,
  parameter int unsigned STEP_W     = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [15:0]       seed,
  input  logic [STEP_W-1:0] max_steps,
  output logic              step_req,
  input  logic              step_ack,
  input  logic              conflict_in,
  input  logic              sat_end,
  input  logic              unsat_end,
  output logic              conflict_out,
  output logic              control,
  output logic [N_VARS-1:0] random_bits,
  output logic              busy,
  output logic              sat,
  output logic              unsat,
  output logic              timeout,
  output logic [STEP_W-1:0] step_count
);

  localparam int unsigned LFSR_W = 16;
  localparam int unsigned SET_W  = (SETTLE_CYC < 1) ? 1 : $clog2(SETTLE_CYC + 1);
  localparam logic [LFSR_W-1:0] LFSR_RST  = 16'h0001;
  localparam logic [LFSR_W-1:0] SEED_ALT  = 16'hACE1;

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_LOAD     = 4'd1;
  localparam logic [3:0] S_CLEAR    = 4'd2;
  localparam logic [3:0] S_ISSUE    = 4'd3;
  localparam logic [3:0] S_WAIT_ACK = 4'd4;
  localparam logic [3:0] S_SETTLE   = 4'd5;
  localparam logic [3:0] S_EVAL     = 4'd6;
  localparam logic [3:0] S_SAT      = 4'd7;
  localparam logic [3:0] S_UNSAT    = 4'd8;
  localparam logic [3:0] S_TIMEOUT  = 4'd9;

  logic [3:0]        state, state_d;
  logic [LFSR_W-1:0] lfsr, lfsr_d, lfsr_adv;
  logic [SET_W-1:0]  settle_cnt, settle_d;
  logic              mode_back, mode_back_d;
  logic [3:0]        sync1, sync2;
  logic              ack_s, conf_s, sat_s, unsat_s;

  logic              step_req_d, conflict_out_d, control_d, busy_d;
  logic              sat_d, unsat_d, timeout_d;
  logic [N_VARS-1:0] random_bits_d;
  logic [STEP_W-1:0] step_count_d;

  // Two-flop synchronizers for the asynchronous chain/clause signals
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {step_ack, conflict_in, sat_end, unsat_end};
      sync2 <= sync1;
    end
  end

  assign ack_s   = sync2[3];
  assign conf_s  = sync2[2];
  assign sat_s   = sync2[1];
  assign unsat_s = sync2[0];

  assign lfsr_adv = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

  // Low 16 vars take the LFSR directly; higher groups are XOR-mixed with one LFSR bit
  function automatic logic [N_VARS-1:0] spread(input logic [LFSR_W-1:0] l);
    logic [N_VARS-1:0] r;
    r = '0;
    for (int i = 0; i < int'(N_VARS); i++) begin
      if (i < int'(LFSR_W)) r[i] = l[4'(i)];
      else                  r[i] = l[4'(i)] ^ l[4'(i / int'(LFSR_W))];
    end
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      lfsr         <= LFSR_RST;
      settle_cnt   <= '0;
      mode_back    <= 1'b0;
      step_req     <= 1'b0;
      conflict_out <= 1'b0;
      control      <= 1'b0;
      busy         <= 1'b0;
      sat          <= 1'b0;
      unsat        <= 1'b0;
      timeout      <= 1'b0;
      random_bits  <= '0;
      step_count   <= '0;
    end else begin
      state        <= state_d;
      lfsr         <= lfsr_d;
      settle_cnt   <= settle_d;
      mode_back    <= mode_back_d;
      step_req     <= step_req_d;
      conflict_out <= conflict_out_d;
      control      <= control_d;
      busy         <= busy_d;
      sat          <= sat_d;
      unsat        <= unsat_d;
      timeout      <= timeout_d;
      random_bits  <= random_bits_d;
      step_count   <= step_count_d;
    end
  end

  always_comb begin
    state_d        = state;
    lfsr_d         = lfsr;
    settle_d       = settle_cnt;
    mode_back_d    = mode_back;
    step_req_d     = step_req;
    conflict_out_d = conflict_out;
    control_d      = control;
    busy_d         = busy;
    sat_d          = sat;
    unsat_d        = unsat;
    timeout_d      = timeout;
    random_bits_d  = random_bits;
    step_count_d   = step_count;

    case (state)
      S_IDLE, S_SAT, S_UNSAT, S_TIMEOUT: begin
        if (start) begin
          state_d   = S_LOAD;
          busy_d    = 1'b1;
          control_d = 1'b0;
        end
      end
      S_LOAD: begin
        lfsr_d       = (seed == 16'h0000) ? SEED_ALT : seed;
        step_count_d = '0;
        sat_d        = 1'b0;
        unsat_d      = 1'b0;
        timeout_d    = 1'b0;
        mode_back_d  = 1'b0;
        control_d    = 1'b1;
        state_d      = S_CLEAR;
      end
      S_CLEAR: begin
        if (!ack_s && !sat_s && !unsat_s) begin
          if (max_steps == '0) begin
            state_d   = S_TIMEOUT;
            timeout_d = 1'b1;
            busy_d    = 1'b0;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        // Never raise a request onto a chain that has not returned to zero
        if (!ack_s) begin
          step_req_d     = 1'b1;
          conflict_out_d = mode_back;
          lfsr_d         = lfsr_adv;
          random_bits_d  = spread(lfsr_adv);
          state_d        = S_WAIT_ACK;
        end
      end
      S_WAIT_ACK: begin
        if (ack_s) begin
          step_req_d     = 1'b0;
          conflict_out_d = 1'b0;
          if (step_count != '1) step_count_d = step_count + STEP_W'(1);
          settle_d       = SET_W'(SETTLE_CYC);
          state_d        = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (settle_cnt != '0) settle_d = settle_cnt - SET_W'(1);
        if (settle_cnt == '0 && !ack_s) state_d = S_EVAL;
      end
      S_EVAL: begin
        if (unsat_s) begin
          state_d = S_UNSAT;
          unsat_d = 1'b1;
          busy_d  = 1'b0;
        end else if (conf_s) begin
          mode_back_d = 1'b1;
          state_d     = S_ISSUE;
        end else if (sat_s) begin
          state_d = S_SAT;
          sat_d   = 1'b1;
          busy_d  = 1'b0;
        end else if (step_count >= max_steps) begin
          state_d   = S_TIMEOUT;
          timeout_d = 1'b1;
          busy_d    = 1'b0;
        end else begin
          mode_back_d = 1'b0;
          state_d     = S_ISSUE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_dpll_step_sequencer.sv
// Bench for dpll_step_sequencer: behavioural var-chain responder, solve vector
// table with a result scoreboard, and hand sequences for reset/start/seed cases.
module tb_dpll_step_sequencer;

  localparam int unsigned N_VARS     = 64;
  localparam int unsigned SETTLE_CYC = 4;
  localparam int unsigned STEP_W     = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [15:0]       seed = 16'h0;
  logic [STEP_W-1:0] max_steps = '0;
  logic              step_req, step_ack, conflict_in, sat_end, unsat_end;
  logic              conflict_out, control, busy, sat, unsat, timeout;
  logic [N_VARS-1:0] random_bits;
  logic [STEP_W-1:0] step_count;

  dpll_step_sequencer #(.N_VARS(N_VARS), .SETTLE_CYC(SETTLE_CYC), .STEP_W(STEP_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .seed(seed), .max_steps(max_steps),
    .step_req(step_req), .step_ack(step_ack), .conflict_in(conflict_in),
    .sat_end(sat_end), .unsat_end(unsat_end), .conflict_out(conflict_out),
    .control(control), .random_bits(random_bits), .busy(busy), .sat(sat),
    .unsat(unsat), .timeout(timeout), .step_count(step_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [15:0] seed;
    int          max_steps;
    int          sat_fwd;
    int          conf_at;
    int          unsat_at;
    int          res;        // 0 sat, 1 unsat, 2 timeout
    int          steps;
    int          backs;
  } vec_t;

  typedef struct {
    string       name;
    logic        sat;
    logic        unsat;
    logic        timeout;
    int          steps;
    int          backs;
    logic        rb_valid;
    logic [63:0] rb;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[9];
  int   tests = 0;
  int   fails = 0;

  // Chain scenario and observed handshake statistics
  int   cfg_sat_fwd = 0, cfg_conf_at = 0, cfg_unsat_at = 0;
  int   m_cnt, m_tot, m_fwd, m_back, m_reqs, m_viol;
  logic m_prev_req, m_req_conf;

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  function automatic logic [63:0] rb_of(input logic [15:0] l);
    logic [63:0] r;
    r[15:0]  = l;
    r[31:16] = l ^ {16{l[1]}};
    r[47:32] = l ^ {16{l[2]}};
    r[63:48] = l ^ {16{l[3]}};
    return r;
  endfunction

  function automatic vec_t mk_vec(input string nm, input logic [15:0] s, input int ms,
                                  input int sf, input int ca, input int ua,
                                  input int res, input int steps, input int backs);
    vec_t v;
    v.name = nm; v.seed = s; v.max_steps = ms; v.sat_fwd = sf; v.conf_at = ca;
    v.unsat_at = ua; v.res = res; v.steps = steps; v.backs = backs;
    return v;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic push_exp(input string nm, input logic [15:0] s, input int res,
                          input int steps, input int backs);
    exp_t e;
    logic [15:0] l;
    e.name = nm;
    e.sat = (res == 0);
    e.unsat = (res == 1);
    e.timeout = (res == 2);
    e.steps = steps;
    e.backs = backs;
    e.rb_valid = (steps > 0);
    l = (s == 16'h0) ? 16'hACE1 : s;
    for (int k = 0; k < steps; k++) l = lfsr_step(l);
    e.rb = rb_of(l);
    sb_q.push_back(e);
  endtask

  task automatic kick(input string nm, input logic [15:0] s, input int ms);
    @(negedge clk);
    seed = s;
    max_steps = 32'(ms);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({nm, "_busy_rise"}, 64'(busy), 64'd1);
  endtask

  task automatic wait_done(input string nm);
    int n;
    n = 0;
    while (busy && n < 4000) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      tests++;
      fails++;
      $display("FAIL %s_done: busy still 1 after %0d cycles", nm, n);
    end
  endtask

  task automatic wait_req(input string nm);
    int n;
    n = 0;
    while (!step_req && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!step_req) begin
      tests++;
      fails++;
      $display("FAIL %s_req: step_req not high after %0d cycles", nm, n);
    end
  endtask

  task automatic check_result();
    exp_t e;
    if (sb_q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL scoreboard: result seen with no expectation queued");
      return;
    end
    e = sb_q.pop_front();
    check({e.name, "_sat"},      64'(sat),        64'(e.sat));
    check({e.name, "_unsat"},    64'(unsat),      64'(e.unsat));
    check({e.name, "_timeout"},  64'(timeout),    64'(e.timeout));
    check({e.name, "_steps"},    64'(step_count), 64'(e.steps));
    check({e.name, "_reqs"},     64'(m_reqs),     64'(e.steps));
    check({e.name, "_backs"},    64'(m_back),     64'(e.backs));
    check({e.name, "_hs_viol"},  64'(m_viol),     64'd0);
    check({e.name, "_control"},  64'(control),    64'd1);
    if (e.rb_valid) check({e.name, "_random_bits"}, 64'(random_bits), e.rb);
  endtask

  // Behavioural var chain: acks 3 cycles after req, drops ack 2 cycles after req falls
  initial begin
    step_ack = 1'b0; conflict_in = 1'b0; sat_end = 1'b0; unsat_end = 1'b0;
    m_cnt = 0; m_tot = 0; m_fwd = 0; m_back = 0; m_reqs = 0; m_viol = 0;
    m_prev_req = 1'b0; m_req_conf = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n || !control) begin
        step_ack = 1'b0; conflict_in = 1'b0; sat_end = 1'b0; unsat_end = 1'b0;
        m_cnt = 0; m_tot = 0; m_fwd = 0; m_back = 0; m_reqs = 0; m_viol = 0;
        m_prev_req = 1'b0; m_req_conf = 1'b0;
      end else begin
        if (step_req && !m_prev_req) begin
          m_reqs++;
          m_req_conf = conflict_out;
          conflict_in = 1'b0;
          m_cnt = 0;
          if (step_ack) m_viol++;
        end
        if (step_req && conflict_out !== m_req_conf) m_viol++;
        if (step_req && !step_ack) begin
          m_cnt++;
          if (m_cnt >= 3) begin
            step_ack = 1'b1;
            m_cnt = 0;
            m_tot++;
            if (m_req_conf) m_back++;
            else m_fwd++;
            if (cfg_unsat_at != 0 && m_tot == cfg_unsat_at) begin
              unsat_end = 1'b1;
              conflict_in = 1'b1;
            end else if (cfg_conf_at != 0 && m_tot == cfg_conf_at) begin
              conflict_in = 1'b1;
            end
            if (cfg_sat_fwd != 0 && !m_req_conf && m_fwd >= cfg_sat_fwd) sat_end = 1'b1;
          end
        end else if (!step_req && step_ack) begin
          m_cnt++;
          if (m_cnt >= 2) begin
            step_ack = 1'b0;
            m_cnt = 0;
          end
        end
        m_prev_req = step_req;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //                 name          seed      max  satF conf unsat res steps backs
    vecs[0] = mk_vec("sat5",        16'h0001, 100, 5,   0,   0,    0,  5,    0);
    vecs[1] = mk_vec("conf2_sat",   16'h0001, 100, 5,   2,   0,    0,  6,    1);
    vecs[2] = mk_vec("unsat4",      16'h0001, 100, 0,   0,   4,    1,  4,    0);
    vecs[3] = mk_vec("limit3",      16'h1234, 3,   0,   0,   0,    2,  3,    0);
    vecs[4] = mk_vec("limit0",      16'h0005, 0,   0,   0,   0,    2,  0,    0);
    vecs[5] = mk_vec("sat_at_lim",  16'h0000, 5,   5,   0,   0,    0,  5,    0);
    vecs[6] = mk_vec("conf_at_lim", 16'h0007, 3,   0,   3,   0,    2,  4,    1);
    vecs[7] = mk_vec("unsat_vs_sat",16'h0009, 100, 3,   0,   3,    1,  3,    0);
    vecs[8] = mk_vec("conf_vs_sat", 16'hBEEF, 100, 4,   4,   0,    0,  5,    1);

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_step_req",     64'(step_req),     64'd0);
    check("rst_conflict_out", 64'(conflict_out), 64'd0);
    check("rst_control",      64'(control),      64'd0);
    check("rst_busy",         64'(busy),         64'd0);
    check("rst_flags",        64'({sat, unsat, timeout}), 64'd0);
    check("rst_step_count",   64'(step_count),   64'd0);
    check("rst_random_bits",  64'(random_bits),  64'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("idle_busy",    64'(busy),    64'd0);
    check("idle_control", 64'(control), 64'd0);
    check("idle_req",     64'(step_req), 64'd0);

    // Solve table
    for (int v = 0; v < 9; v++) begin
      cfg_sat_fwd  = vecs[v].sat_fwd;
      cfg_conf_at  = vecs[v].conf_at;
      cfg_unsat_at = vecs[v].unsat_at;
      push_exp(vecs[v].name, vecs[v].seed, vecs[v].res, vecs[v].steps, vecs[v].backs);
      kick(vecs[v].name, vecs[v].seed, vecs[v].max_steps);
      wait_done(vecs[v].name);
      check_result();
    end

    // Zero seed substitutes 0xACE1; first issued step carries its advanced bits
    cfg_sat_fwd = 1; cfg_conf_at = 0; cfg_unsat_at = 0;
    push_exp("seed0", 16'h0000, 0, 1, 0);
    kick("seed0", 16'h0000, 100);
    wait_req("seed0");
    check("seed0_first_rb", 64'(random_bits), rb_of(lfsr_step(16'hACE1)));
    wait_done("seed0");
    check_result();

    // start while busy must not reload the seed or restart
    cfg_sat_fwd = 3; cfg_conf_at = 0; cfg_unsat_at = 0;
    push_exp("start_busy", 16'h00F0, 0, 3, 0);
    kick("start_busy", 16'h00F0, 100);
    wait_req("start_busy");
    seed = 16'h5555;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("start_busy");
    check_result();

    // Reset in the middle of a request phase clears everything at once
    cfg_sat_fwd = 0; cfg_conf_at = 0; cfg_unsat_at = 0;
    kick("rst_mid", 16'h0101, 100);
    wait_req("rst_mid");
    rst_n = 1'b0;
    #1;
    check("rst_mid_step_req", 64'(step_req), 64'd0);
    check("rst_mid_control",  64'(control),  64'd0);
    check("rst_mid_busy",     64'(busy),     64'd0);
    check("rst_mid_flags",    64'({sat, unsat, timeout}), 64'd0);
    check("rst_mid_steps",    64'(step_count), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_mid_idle_busy", 64'(busy), 64'd0);
    check("rst_mid_no_result", 64'({sat, unsat, timeout}), 64'd0);
    check("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
